expr_sig_compactor: RTL and testbench

EXPR_SIG_COMPACTOR -- requirements
Module: expr_sig_compactor

---
 rtl/expr_sig_pkg.sv | 19 +
 rtl/expr_sig_misr.sv | 34 +++
 rtl/expr_sig_compactor.sv | 115 +++++++++++
 tb/tb_expr_sig_compactor.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/expr_sig_pkg.sv
// Shared types and constants for the expression-signature compactor.
package expr_sig_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned DefWidth = 90;
  localparam int unsigned DefCntW  = 16;

  // Feedback taps are taken from bit (WIDTH - TapN).
  localparam int unsigned Tap0 = 1;
  localparam int unsigned Tap1 = 2;
  localparam int unsigned Tap2 = 3;
  localparam int unsigned Tap3 = 4;

endpackage

// File: rtl/expr_sig_misr.sv
// Multiple-input signature register: shift-left with four-tap feedback XORed with the data word.
module expr_sig_misr
  import expr_sig_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             en,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] sig
);

  logic             fb;
  logic [WIDTH-1:0] sig_next;

  always_comb begin
    fb       = sig[WIDTH-Tap0] ^ sig[WIDTH-Tap1] ^ sig[WIDTH-Tap2] ^ sig[WIDTH-Tap3];
    sig_next = {sig[WIDTH-2:0], fb} ^ data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig <= seed;
    end else if (load) begin
      sig <= seed;
    end else if (en) begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/expr_sig_compactor.sv
// Captures a counted run of expression results into a MISR and hands out the signature.
// Optional even-parity checking of in_data is enabled by defining EXPR_SIG_PARITY_EN.
module expr_sig_compactor
  import expr_sig_pkg::*;
#(
  parameter int unsigned      WIDTH = DefWidth,
  parameter int unsigned      CNT_W = DefCntW,
  parameter logic [WIDTH-1:0] SEED  = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             sig_valid,
  input  logic             sig_ready,
  output logic [WIDTH-1:0] sig_out,
  output logic [CNT_W-1:0] vec_count,
  output logic             busy
`ifdef EXPR_SIG_PARITY_EN
  ,
  input  logic             in_par,
  output logic             par_err
`endif
);

  state_e           state;
  logic [CNT_W-1:0] num_lat;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;
  logic             load;

  always_comb begin
    accept  = in_valid & in_ready;
    load    = (state == StIdle) & start;
    cnt_inc = vec_count + CNT_W'(1);
  end

  expr_sig_misr #(
    .WIDTH(WIDTH)
  ) u_misr (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .seed (SEED),
    .en   (accept),
    .data (in_data),
    .sig  (sig_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= StIdle;
      num_lat   <= '0;
      vec_count <= '0;
      in_ready  <= 1'b0;
      sig_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (start) begin
            num_lat   <= num_vec;
            vec_count <= '0;
            busy      <= 1'b1;
            if (num_vec == '0) begin
              state     <= StDone;
              sig_valid <= 1'b1;
            end else begin
              state    <= StRun;
              in_ready <= 1'b1;
            end
          end
        end
        StRun: begin
          if (accept) begin
            vec_count <= cnt_inc;
            if (cnt_inc == num_lat) begin
              state     <= StDone;
              in_ready  <= 1'b0;
              sig_valid <= 1'b1;
            end
          end
        end
        StDone: begin
          if (sig_ready) begin
            state     <= StIdle;
            sig_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= StIdle;
          in_ready  <= 1'b0;
          sig_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef EXPR_SIG_PARITY_EN
  // Sticky until the next accepted start or reset.
  always_ff @(posedge clk) begin
    if (!rst_n || load) begin
      par_err <= 1'b0;
    end else if (accept && ((^in_data) != in_par)) begin
      par_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_expr_sig_compactor.sv
// Directed self-checking bench for expr_sig_compactor.
module tb_expr_sig_compactor;

  localparam int unsigned W = 90;
  localparam int unsigned C = 16;
  localparam logic [W-1:0] Seed = '1;

  logic         clk = 1'b0;
  logic         rst_n, start, in_valid, sig_ready;
  logic [C-1:0] num_vec;
  logic [W-1:0] in_data;
  logic         in_ready, sig_valid, busy;
  logic [W-1:0] sig_out;
  logic [C-1:0] vec_count;
`ifdef EXPR_SIG_PARITY_EN
  logic         in_par, par_err;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  expr_sig_compactor dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .num_vec  (num_vec),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .sig_valid(sig_valid),
    .sig_ready(sig_ready),
    .sig_out  (sig_out),
    .vec_count(vec_count),
    .busy     (busy)
`ifdef EXPR_SIG_PARITY_EN
    ,
    .in_par   (in_par),
    .par_err  (par_err)
`endif
  );

  function automatic logic [W-1:0] step(input logic [W-1:0] m, input logic [W-1:0] d);
    logic fb;
    fb = m[W-1] ^ m[W-2] ^ m[W-3] ^ m[W-4];
    return {m[W-2:0], fb} ^ d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  logic [W-1:0] m;
  logic [W-1:0] vecs [4];
  int           beats;

  initial begin
    vecs[0] = 90'h155_5555_5555_5555_5555_5555;
    vecs[1] = 90'h0AB_CDEF_0123_4567_89AB_CDEF;
    vecs[2] = 90'h200_0000_0000_0000_0000_0001;
    vecs[3] = 90'h0F0_F0F0_1234_0000_FFFF_8001;

    rst_n = 1'b0; start = 1'b0; num_vec = '0; in_valid = 1'b0; in_data = '0; sig_ready = 1'b0;
`ifdef EXPR_SIG_PARITY_EN
    in_par = 1'b0;
`endif
    tick();
    check("rst_busy", W'(busy), W'(0));
    check("rst_in_ready", W'(in_ready), W'(0));
    check("rst_sig_valid", W'(sig_valid), W'(0));
    check("rst_vec_count", W'(vec_count), W'(0));
    check("rst_sig_out", sig_out, Seed);
    rst_n = 1'b1;
    tick();

    // num_vec = 0: straight to DONE with the seed as signature
    start = 1'b1; num_vec = 0;
    tick();
    start = 1'b0;
    check("zero_sig_valid", W'(sig_valid), W'(1));
    check("zero_in_ready", W'(in_ready), W'(0));
    check("zero_busy", W'(busy), W'(1));
    check("zero_sig_out", sig_out, Seed);
    check("zero_vec_count", W'(vec_count), W'(0));
    sig_ready = 1'b1;
    tick();
    sig_ready = 1'b0;
    check("zero_back_idle", W'({busy, sig_valid}), W'(0));

    // single all-zero beat
    start = 1'b1; num_vec = 1;
    tick();
    start = 1'b0;
    check("one_in_ready", W'(in_ready), W'(1));
    in_valid = 1'b1; in_data = '0;
    tick();
    in_valid = 1'b0;
    check("one_sig_valid", W'(sig_valid), W'(1));
    check("one_sig_out", sig_out, {{(W-1){1'b1}}, 1'b0});
    check("one_vec_count", W'(vec_count), W'(1));
    check("one_in_ready_low", W'(in_ready), W'(0));
    sig_ready = 1'b1;
    tick();
    sig_ready = 1'b0;

    // four beats with in_valid toggling
    start = 1'b1; num_vec = 4;
    tick();
    start = 1'b0;
    m = Seed; beats = 0;
    for (int i = 0; i < 7; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = vecs[i/2];
      tick();
      if (i % 2 == 0) begin
        m = step(m, vecs[i/2]);
        beats++;
      end
      if (i == 5) check("four_not_done_yet", W'(sig_valid), W'(0));
      if (i == 1) check("four_stall_count", W'(vec_count), W'(1));
    end
    check("four_sig_valid", W'(sig_valid), W'(1));
    check("four_sig_out", sig_out, m);
    check("four_vec_count", W'(vec_count), W'(beats));
    in_valid = 1'b1; in_data = vecs[1];
    tick();
    in_valid = 1'b0;
    check("four_no_extra_beat", W'(vec_count), W'(4));
    check("four_sig_held", sig_out, m);

    // hold in DONE for 5 cycles while start pulses
    for (int i = 0; i < 5; i++) begin
      start = (i % 2 == 0);
      tick();
      check("hold_sig_valid", W'(sig_valid), W'(1));
      check("hold_sig_out", sig_out, m);
    end
    start = 1'b1; sig_ready = 1'b1;
    tick();
    start = 1'b0; sig_ready = 1'b0;
    check("hold_release_idle", W'({busy, sig_valid, in_ready}), W'(0));
    tick();
    check("hold_start_ignored", W'(busy), W'(0));

    // reset mid-run after 3 of 8 beats
    start = 1'b1; num_vec = 8;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = vecs[i];
      tick();
    end
    in_valid = 1'b0;
    check("mid_vec_count", W'(vec_count), W'(3));
    rst_n = 1'b0;
    tick();
    check("mid_rst_state", W'({busy, sig_valid, in_ready}), W'(0));
    check("mid_rst_count", W'(vec_count), W'(0));
    check("mid_rst_sig", sig_out, Seed);
    rst_n = 1'b1;
    start = 1'b1; num_vec = 2;
    tick();
    start = 1'b0;
    m = Seed;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = vecs[3-i];
      m = step(m, vecs[3-i]);
      tick();
    end
    in_valid = 1'b0;
    check("rerun_sig_valid", W'(sig_valid), W'(1));
    check("rerun_sig_out", sig_out, m);
    check("rerun_vec_count", W'(vec_count), W'(2));
    sig_ready = 1'b1;
    tick();
    sig_ready = 1'b0;

`ifdef EXPR_SIG_PARITY_EN
    start = 1'b1; num_vec = 2;
    tick();
    start = 1'b0;
    check("par_clear", W'(par_err), W'(0));
    in_valid = 1'b1; in_data = W'(1); in_par = 1'b0;
    tick();
    check("par_set", W'(par_err), W'(1));
    in_data = W'(3); in_par = 1'b0;
    tick();
    in_valid = 1'b0;
    check("par_sticky_done", W'(par_err), W'(1));
    sig_ready = 1'b1;
    tick();
    sig_ready = 1'b0;
    start = 1'b1; num_vec = 1;
    tick();
    start = 1'b0;
    check("par_start_clears", W'(par_err), W'(0));
    in_valid = 1'b1; in_data = W'(3); in_par = 1'b0;
    tick();
    in_valid = 1'b0;
    check("par_good_beat", W'(par_err), W'(0));
    sig_ready = 1'b1;
    tick();
    sig_ready = 1'b0;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
